control_sequencer: RTL and testbench

- Microcoded control unit for the Bat Amateur processor.
- Steps through fetch/execute T-states and drives the LOAD/ENABLE/COUNT strobes of the PC, MAR, RAM, IR, A, B, ALU, flag and output registers on the shared bus.
- Decodes the opcode from the instruction register's INSTRUCTION_OUT.
- Supports halt and single-step operation.

---
 rtl/control_sequencer.sv | 170 +++++++++++++++++
 tb/tb_control_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control unit for the Bat Amateur processor: walks the fetch/execute
// T-states and decodes the opcode into the bus LOAD/ENABLE/COUNT strobes.
module control_sequencer #(
    parameter int BUS_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [BUS_WIDTH-1:0] INSTRUCTION,
    input  logic                 CARRY_FLAG,
    input  logic                 ZERO_FLAG,
    input  logic                 STEP_MODE,
    input  logic                 STEP,
    output logic                 PC_COUNT,
    output logic                 PC_ENABLE,
    output logic                 PC_LOAD,
    output logic                 MAR_LOAD,
    output logic                 RAM_ENABLE,
    output logic                 RAM_LOAD,
    output logic                 IR_LOAD,
    output logic                 IR_ENABLE,
    output logic                 A_LOAD,
    output logic                 A_ENABLE,
    output logic                 B_LOAD,
    output logic                 ALU_ENABLE,
    output logic                 ALU_SUB,
    output logic                 FLAGS_LOAD,
    output logic                 OUT_LOAD,
    output logic                 HALTED,
    output logic [2:0]           T_STATE
);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd7
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    state_legal_s;
    logic [OPCODE_WIDTH-1:0] opcode_s;
    logic                    adv_s;
    logic                    gate_s;
    logic [2:0]              t_state_s;
    logic                    unused_operand_s;
    logic pc_count_s, pc_enable_s, pc_load_s, mar_load_s, ram_enable_s, ram_load_s;
    logic ir_load_s, ir_enable_s, a_load_s, a_enable_s, b_load_s;
    logic alu_enable_s, alu_sub_s, flags_load_s, out_load_s;

    assign opcode_s         = INSTRUCTION[BUS_WIDTH-1 -: OPCODE_WIDTH];
    assign unused_operand_s = ^INSTRUCTION[BUS_WIDTH-OPCODE_WIDTH-1:0];
    assign adv_s            = !STEP_MODE || STEP;
    // Strobes fire only on an advancing, non-reset cycle so a held step never repeats a load or count.
    assign gate_s           = adv_s && !RESET;

    // Microcode decode: next state and raw strobes from the current step and opcode.
    always_comb begin
        state_next_s  = state_r;
        state_legal_s = 1'b1;
        t_state_s     = 3'd0;
        pc_count_s    = 1'b0; pc_enable_s = 1'b0; pc_load_s    = 1'b0; mar_load_s   = 1'b0;
        ram_enable_s  = 1'b0; ram_load_s  = 1'b0; ir_load_s    = 1'b0; ir_enable_s  = 1'b0;
        a_load_s      = 1'b0; a_enable_s  = 1'b0; b_load_s     = 1'b0; alu_enable_s = 1'b0;
        alu_sub_s     = 1'b0; flags_load_s = 1'b0; out_load_s  = 1'b0;
        case (state_r)
            T0: begin
                t_state_s = 3'd0; state_next_s = T1;
                pc_enable_s = 1'b1; mar_load_s = 1'b1;
            end
            T1: begin
                t_state_s = 3'd1; state_next_s = T2;
                ram_enable_s = 1'b1; ir_load_s = 1'b1; pc_count_s = 1'b1;
            end
            T2: begin
                t_state_s = 3'd2; state_next_s = T0;
                case (opcode_s)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ir_enable_s = 1'b1; mar_load_s = 1'b1; state_next_s = T3;
                    end
                    OP_LDI: begin ir_enable_s = 1'b1; a_load_s = 1'b1; end
                    OP_JMP: begin ir_enable_s = 1'b1; pc_load_s = 1'b1; end
                    OP_JC: begin
                        if (CARRY_FLAG) begin ir_enable_s = 1'b1; pc_load_s = 1'b1; end
                        else begin ir_enable_s = 1'b0; pc_load_s = 1'b0; end
                    end
                    OP_JZ: begin
                        if (ZERO_FLAG) begin ir_enable_s = 1'b1; pc_load_s = 1'b1; end
                        else begin ir_enable_s = 1'b0; pc_load_s = 1'b0; end
                    end
                    OP_OUT: begin a_enable_s = 1'b1; out_load_s = 1'b1; end
                    OP_HLT: state_next_s = HALT;
                    default: state_next_s = T0;
                endcase
            end
            T3: begin
                t_state_s = 3'd3; state_next_s = T0;
                case (opcode_s)
                    OP_LDA: begin ram_enable_s = 1'b1; a_load_s = 1'b1; end
                    OP_ADD: begin ram_enable_s = 1'b1; b_load_s = 1'b1; state_next_s = T4; end
                    OP_SUB: begin
                        ram_enable_s = 1'b1; b_load_s = 1'b1; alu_sub_s = 1'b1; state_next_s = T4;
                    end
                    OP_STA: begin a_enable_s = 1'b1; ram_load_s = 1'b1; end
                    default: state_next_s = T0;
                endcase
            end
            T4: begin
                t_state_s = 3'd4; state_next_s = T0;
                case (opcode_s)
                    OP_ADD: begin alu_enable_s = 1'b1; a_load_s = 1'b1; flags_load_s = 1'b1; end
                    OP_SUB: begin
                        alu_enable_s = 1'b1; a_load_s = 1'b1; flags_load_s = 1'b1; alu_sub_s = 1'b1;
                    end
                    default: state_next_s = T0;
                endcase
            end
            HALT: begin
                t_state_s = 3'd7; state_next_s = HALT;
            end
            default: begin
                state_legal_s = 1'b0; state_next_s = T0;
            end
        endcase
    end

    // State register: illegal encodings recover even while the step gate is closed.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r <= T0;
        end else if (adv_s || !state_legal_s) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign PC_COUNT   = pc_count_s   && gate_s;
    assign PC_ENABLE  = pc_enable_s  && gate_s;
    assign PC_LOAD    = pc_load_s    && gate_s;
    assign MAR_LOAD   = mar_load_s   && gate_s;
    assign RAM_ENABLE = ram_enable_s && gate_s;
    assign RAM_LOAD   = ram_load_s   && gate_s;
    assign IR_LOAD    = ir_load_s    && gate_s;
    assign IR_ENABLE  = ir_enable_s  && gate_s;
    assign A_LOAD     = a_load_s     && gate_s;
    assign A_ENABLE   = a_enable_s   && gate_s;
    assign B_LOAD     = b_load_s     && gate_s;
    assign ALU_ENABLE = alu_enable_s && gate_s;
    assign ALU_SUB    = alu_sub_s    && gate_s;
    assign FLAGS_LOAD = flags_load_s && gate_s;
    assign OUT_LOAD   = out_load_s   && gate_s;
    assign HALTED     = (state_r == HALT) && !RESET;
    assign T_STATE    = RESET ? 3'd0 : t_state_s;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus randomized
// traffic, every cycle compared against a step-counting microcode model.
module tb_control_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET, CARRY_FLAG, ZERO_FLAG, STEP_MODE, STEP;
    logic [15:0] INSTRUCTION;
    logic PC_COUNT, PC_ENABLE, PC_LOAD, MAR_LOAD, RAM_ENABLE, RAM_LOAD, IR_LOAD, IR_ENABLE;
    logic A_LOAD, A_ENABLE, B_LOAD, ALU_ENABLE, ALU_SUB, FLAGS_LOAD, OUT_LOAD, HALTED;
    logic [2:0] T_STATE;

    localparam logic [14:0] S_PCC  = 15'h4000, S_PCE = 15'h2000, S_PCL = 15'h1000;
    localparam logic [14:0] S_MAR  = 15'h0800, S_RAME = 15'h0400, S_RAML = 15'h0200;
    localparam logic [14:0] S_IRL  = 15'h0100, S_IRE = 15'h0080, S_AL = 15'h0040;
    localparam logic [14:0] S_AE   = 15'h0020, S_BL = 15'h0010, S_ALUE = 15'h0008;
    localparam logic [14:0] S_SUB  = 15'h0004, S_FL = 15'h0002, S_OUT = 15'h0001;

    control_sequencer #(.BUS_WIDTH(16), .OPCODE_WIDTH(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
        .CARRY_FLAG(CARRY_FLAG), .ZERO_FLAG(ZERO_FLAG), .STEP_MODE(STEP_MODE), .STEP(STEP),
        .PC_COUNT(PC_COUNT), .PC_ENABLE(PC_ENABLE), .PC_LOAD(PC_LOAD), .MAR_LOAD(MAR_LOAD),
        .RAM_ENABLE(RAM_ENABLE), .RAM_LOAD(RAM_LOAD), .IR_LOAD(IR_LOAD), .IR_ENABLE(IR_ENABLE),
        .A_LOAD(A_LOAD), .A_ENABLE(A_ENABLE), .B_LOAD(B_LOAD), .ALU_ENABLE(ALU_ENABLE),
        .ALU_SUB(ALU_SUB), .FLAGS_LOAD(FLAGS_LOAD), .OUT_LOAD(OUT_LOAD),
        .HALTED(HALTED), .T_STATE(T_STATE)
    );

    always #5 CLOCK = ~CLOCK;

    wire [14:0] act_w = {PC_COUNT, PC_ENABLE, PC_LOAD, MAR_LOAD, RAM_ENABLE, RAM_LOAD, IR_LOAD,
                         IR_ENABLE, A_LOAD, A_ENABLE, B_LOAD, ALU_ENABLE, ALU_SUB, FLAGS_LOAD,
                         OUT_LOAD};
    wire [4:0]  drv_w = {PC_ENABLE, RAM_ENABLE, IR_ENABLE, A_ENABLE, ALU_ENABLE};

    int          checks = 0;
    int          errors = 0;
    int          m_step = 0;
    bit          m_halted = 1'b0;
    logic [14:0] exp_s;
    logic [2:0]  exp_t;
    logic        exp_h;

    // Index of the final step for each opcode (HLT ends at step 2, then halts).
    function automatic int last_step(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 3;
            4'h2, 4'h3: return 4;
            default:    return 2;
        endcase
    endfunction

    // Strobe table from the instruction set description.
    function automatic logic [14:0] ucode(input logic [3:0] op, input int step,
                                          input logic c, input logic z);
        logic [14:0] s;
        s = 15'h0;
        if (step == 0) s = S_PCE | S_MAR;
        else if (step == 1) s = S_RAME | S_IRL | S_PCC;
        else if (step == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: s = S_IRE | S_MAR;
                4'h5: s = S_IRE | S_AL;
                4'h6: s = S_IRE | S_PCL;
                4'h7: s = c ? (S_IRE | S_PCL) : 15'h0;
                4'h8: s = z ? (S_IRE | S_PCL) : 15'h0;
                4'hE: s = S_AE | S_OUT;
                default: s = 15'h0;
            endcase
        end else if (step == 3) begin
            case (op)
                4'h1: s = S_RAME | S_AL;
                4'h2: s = S_RAME | S_BL;
                4'h3: s = S_RAME | S_BL | S_SUB;
                4'h4: s = S_AE | S_RAML;
                default: s = 15'h0;
            endcase
        end else if (step == 4) begin
            case (op)
                4'h2: s = S_ALUE | S_AL | S_FL;
                4'h3: s = S_ALUE | S_AL | S_FL | S_SUB;
                default: s = 15'h0;
            endcase
        end
        return s;
    endfunction

    task automatic model_expect();
        if (RESET) begin
            exp_s = 15'h0; exp_t = 3'd0; exp_h = 1'b0;
        end else if (m_halted) begin
            exp_s = 15'h0; exp_t = 3'd7; exp_h = 1'b1;
        end else begin
            exp_t = 3'(m_step); exp_h = 1'b0;
            exp_s = (!STEP_MODE || STEP) ? ucode(INSTRUCTION[15:12], m_step, CARRY_FLAG, ZERO_FLAG)
                                         : 15'h0;
        end
    endtask

    task automatic model_advance();
        if (RESET) begin
            m_step = 0; m_halted = 1'b0;
        end else if (!m_halted && (!STEP_MODE || STEP)) begin
            if (m_step == last_step(INSTRUCTION[15:12])) begin
                if (INSTRUCTION[15:12] == 4'hF) m_halted = 1'b1;
                m_step = 0;
            end else begin
                m_step = m_step + 1;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; INSTRUCTION = 16'h1005; CARRY_FLAG = 1'b0; ZERO_FLAG = 1'b0;
        STEP_MODE = 1'b0; STEP = 1'b0;
        for (int i = 0; i < 2; i++) begin
            model_expect();
            @(negedge CLOCK);
            checks++;
            if ({HALTED, T_STATE, act_w} !== {exp_h, exp_t, exp_s}) begin
                errors++;
                $display("FAIL reset cyc%0d got h=%b t=%0d s=%h want h=%b t=%0d s=%h",
                         i, HALTED, T_STATE, act_w, exp_h, exp_t, exp_s);
            end
            @(posedge CLOCK); model_advance(); #1;
        end
        RESET = 1'b0;
    endtask

    task automatic test_lda();
        INSTRUCTION = 16'h1005; STEP_MODE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            model_expect();
            @(negedge CLOCK);
            checks++;
            if ({HALTED, T_STATE, act_w} !== {exp_h, exp_t, exp_s}) begin
                errors++;
                $display("FAIL lda cyc%0d got h=%b t=%0d s=%h want h=%b t=%0d s=%h",
                         i, HALTED, T_STATE, act_w, exp_h, exp_t, exp_s);
            end
            checks++;
            if ($countones(drv_w) > 1) begin
                errors++; $display("FAIL lda_bus cyc%0d drivers=%b want at most one", i, drv_w);
            end
            @(posedge CLOCK); model_advance(); #1;
        end
    endtask

    task automatic test_sub();
        INSTRUCTION = 16'h3007;
        for (int i = 0; i < 6; i++) begin
            model_expect();
            @(negedge CLOCK);
            checks++;
            if ({HALTED, T_STATE, act_w} !== {exp_h, exp_t, exp_s}) begin
                errors++;
                $display("FAIL sub cyc%0d got h=%b t=%0d s=%h want h=%b t=%0d s=%h",
                         i, HALTED, T_STATE, act_w, exp_h, exp_t, exp_s);
            end
            @(posedge CLOCK); model_advance(); #1;
        end
    endtask

    task automatic test_jc();
        int pcl_cnt;
        pcl_cnt = 0;
        INSTRUCTION = 16'h700A;
        for (int i = 0; i < 6; i++) begin
            CARRY_FLAG = (i >= 3);
            model_expect();
            @(negedge CLOCK);
            if (PC_LOAD) pcl_cnt++;
            checks++;
            if ({HALTED, T_STATE, act_w} !== {exp_h, exp_t, exp_s}) begin
                errors++;
                $display("FAIL jc cyc%0d got h=%b t=%0d s=%h want h=%b t=%0d s=%h",
                         i, HALTED, T_STATE, act_w, exp_h, exp_t, exp_s);
            end
            @(posedge CLOCK); model_advance(); #1;
        end
        checks++;
        if (pcl_cnt !== 1) begin
            errors++; $display("FAIL jc_pc_load_count got %0d want 1", pcl_cnt);
        end
        CARRY_FLAG = 1'b0;
    endtask

    task automatic test_halt();
        int h_cnt;
        h_cnt = 0;
        INSTRUCTION = 16'hF000;
        for (int i = 0; i < 25; i++) begin
            RESET = (i == 23);
            if (i >= 3 && i < 23) begin
                STEP = i[0]; STEP_MODE = 1'($urandom_range(0, 1));
            end else begin
                STEP = 1'b0; STEP_MODE = 1'b0;
            end
            model_expect();
            @(negedge CLOCK);
            if (i >= 3 && i < 23 && HALTED) h_cnt++;
            checks++;
            if ({HALTED, T_STATE, act_w} !== {exp_h, exp_t, exp_s}) begin
                errors++;
                $display("FAIL halt cyc%0d got h=%b t=%0d s=%h want h=%b t=%0d s=%h",
                         i, HALTED, T_STATE, act_w, exp_h, exp_t, exp_s);
            end
            @(posedge CLOCK); model_advance(); #1;
        end
        checks++;
        if (h_cnt !== 20) begin
            errors++; $display("FAIL halt_hold_count got %0d want 20", h_cnt);
        end
        RESET = 1'b0;
    endtask

    task automatic test_single_step();
        int pcc_cnt;
        pcc_cnt = 0;
        INSTRUCTION = 16'h5042; STEP_MODE = 1'b1;
        for (int i = 0; i < 24; i++) begin
            STEP = ((i % 4) == 3);
            model_expect();
            @(negedge CLOCK);
            if (PC_COUNT) pcc_cnt++;
            checks++;
            if ({HALTED, T_STATE, act_w} !== {exp_h, exp_t, exp_s}) begin
                errors++;
                $display("FAIL single_step cyc%0d got h=%b t=%0d s=%h want h=%b t=%0d s=%h",
                         i, HALTED, T_STATE, act_w, exp_h, exp_t, exp_s);
            end
            @(posedge CLOCK); model_advance(); #1;
        end
        checks++;
        if (pcc_cnt !== 2) begin
            errors++; $display("FAIL single_step_pc_count got %0d want 2", pcc_cnt);
        end
        STEP_MODE = 1'b0; STEP = 1'b0;
    endtask

    task automatic test_reset_mid();
        int al_cnt;
        al_cnt = 0;
        INSTRUCTION = 16'h2003;
        for (int i = 0; i < 5; i++) begin
            RESET = (i == 3);
            model_expect();
            @(negedge CLOCK);
            if (A_LOAD || FLAGS_LOAD) al_cnt++;
            checks++;
            if ({HALTED, T_STATE, act_w} !== {exp_h, exp_t, exp_s}) begin
                errors++;
                $display("FAIL reset_mid cyc%0d got h=%b t=%0d s=%h want h=%b t=%0d s=%h",
                         i, HALTED, T_STATE, act_w, exp_h, exp_t, exp_s);
            end
            checks++;
            if ($countones(drv_w) > 1) begin
                errors++; $display("FAIL reset_mid_bus cyc%0d drivers=%b want at most one", i, drv_w);
            end
            @(posedge CLOCK); model_advance(); #1;
        end
        checks++;
        if (al_cnt !== 0) begin
            errors++; $display("FAIL reset_mid_aload_count got %0d want 0", al_cnt);
        end
        RESET = 1'b0;
    endtask

    task automatic test_random();
        STEP_MODE = 1'b0;
        for (int i = 0; i < 800; i++) begin
            RESET = ($urandom_range(0, 39) == 0);
            if (m_step == 0 && !m_halted) INSTRUCTION = 16'($urandom);
            CARRY_FLAG = 1'($urandom_range(0, 1));
            ZERO_FLAG  = 1'($urandom_range(0, 1));
            STEP       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) STEP_MODE = ~STEP_MODE;
            model_expect();
            @(negedge CLOCK);
            checks++;
            if ({HALTED, T_STATE, act_w} !== {exp_h, exp_t, exp_s}) begin
                errors++;
                $display("FAIL random cyc%0d op=%h got h=%b t=%0d s=%h want h=%b t=%0d s=%h",
                         i, INSTRUCTION[15:12], HALTED, T_STATE, act_w, exp_h, exp_t, exp_s);
            end
            checks++;
            if ($countones(drv_w) > 1) begin
                errors++; $display("FAIL random_bus cyc%0d drivers=%b want at most one", i, drv_w);
            end
            @(posedge CLOCK); model_advance(); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sub();
        test_jc();
        test_halt();
        test_single_step();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
